// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned/signed/mixed operands.
// Optional SEQ_MULT_EARLY_TERM_EN finishes opcodes 01/11 once no set multiplier bits remain.
module seq_mult #(
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      opcode,
    input  logic [BW-1:0]   multiplicand,
    input  logic [BW-1:0]   multiplier,
    input  logic            abort,
    output logic [2*BW-1:0] result,
    output logic            done,
    output logic            busy
);
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_reg;
    logic [1:0]          op_reg;
    logic [BW-1:0]       a_reg;
    logic [BW-1:0]       b_reg;
    logic [BW-1:0]       lo_reg;
    logic [BW:0]         acc_reg;
    logic [CW-1:0]       cnt_reg;
    logic [2*BW-1:0]     result_reg;
    logic                done_reg;
    logic                busy_reg;

    logic                signed_a;
    logic                last_iter;
    logic                cur_bit;
    logic                finish;
    logic [BW:0]         a_ext;
    logic [BW:0]         addend;
    logic [BW:0]         sum;
    logic [2*BW:0]       pair;
    logic signed [2*BW:0] pair_s;
    logic signed [2*BW:0] asr1;
    logic [2*BW:0]       lsr1;
    logic [2*BW:0]       nxt;
    logic [2*BW:0]       final_pair;

    assign signed_a  = (op_reg != 2'b01);
    assign last_iter = (cnt_reg == CW'(BW - 1));
    assign cur_bit   = b_reg[cnt_reg];
    assign a_ext     = {signed_a & a_reg[BW-1], a_reg};

    // Signed x signed: the multiplier MSB carries negative weight, so it subtracts.
    assign addend = !cur_bit ? '0 :
                    ((op_reg == 2'b10) && last_iter) ? -a_ext : a_ext;
    assign sum    = acc_reg + addend;

    // Accumulator and collected low product bits shift right as one register pair.
    assign pair   = {sum, lo_reg};
    assign pair_s = pair;
    assign asr1   = pair_s >>> 1;
    assign lsr1   = pair >> 1;
    assign nxt    = signed_a ? asr1 : lsr1;

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic                upper_zero;
    logic [CW:0]         sh;
    logic signed [2*BW:0] asr_f;
    logic [2*BW:0]       lsr_f;

    assign upper_zero = (((b_reg >> cnt_reg) >> 1) == '0);
    assign finish     = last_iter || ((op_reg != 2'b10) && upper_zero);
    // Remaining shifts collapse into one: BW total minus cnt_reg already applied.
    assign sh         = (CW+1)'(BW) - (CW+1)'(cnt_reg);
    assign asr_f      = pair_s >>> sh;
    assign lsr_f      = pair >> sh;
    assign final_pair = signed_a ? asr_f : lsr_f;
`else
    assign finish     = last_iter;
    assign final_pair = nxt;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            op_reg     <= 2'b00;
            a_reg      <= '0;
            b_reg      <= '0;
            lo_reg     <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start_valid && (opcode != 2'b00)) begin
                        op_reg    <= opcode;
                        a_reg     <= multiplicand;
                        b_reg     <= multiplier;
                        acc_reg   <= '0;
                        lo_reg    <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    if (abort) begin
                        result_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end else if (finish) begin
                        result_reg <= (2*BW)'(final_pair);
                        done_reg   <= 1'b1;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b0;
                        state_reg  <= DONE;
                    end else begin
                        acc_reg <= nxt[2*BW:BW];
                        lo_reg  <= nxt[BW-1:0];
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign result      = result_reg;
    assign done        = done_reg;
    assign busy        = busy_reg;
endmodule
